// File: rtl/code_tally_pkg.sv
// Shared types and sizing for the code histogram block.
package code_tally_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned NUM_BINS = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        DUMP    = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/code_tally.sv
// Windowed histogram of 3-bit codes: collects WIN samples into 8 saturating
// bins, then streams the bins out as eight valid/ready beats and clears them.
module code_tally
    import code_tally_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [2:0]        in_code,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_bin,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last
);

    localparam int unsigned SC_W = $clog2(WIN + 1);

    state_t            state;
    state_t            state_next;
    logic [SC_W-1:0]   sc;
    logic [CNT_W-1:0]  bin_cnt [NUM_BINS];

    logic accept;
    logic window_done;
    logic beat;
    logic dump_done;

    assign accept      = in_valid & in_ready;
    assign window_done = accept & (sc == SC_W'(WIN - 1));
    assign beat        = out_valid & out_ready;
    assign dump_done   = beat & out_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (window_done) state_next = DUMP;
            DUMP:    if (dump_done)   state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Outputs decoded from registered state, bin index and bin counters only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_count = '0;
        case (state)
            COLLECT: in_ready = 1'b1;
            DUMP: begin
                out_valid = 1'b1;
                out_last  = (out_bin == CODE_W'(NUM_BINS - 1));
                out_count = bin_cnt[out_bin];
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Accepted-sample counter for the current window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= '0;
        end else if (dump_done) begin
            sc <= '0;
        end else if (accept) begin
            sc <= sc + SC_W'(1);
        end
    end

    // Beat index; wraps back to 0 after the bin-7 beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bin <= '0;
        end else if (window_done) begin
            out_bin <= '0;
        end else if (beat) begin
            out_bin <= out_bin + CODE_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (accept && (in_code == CODE_W'(g))),
            .clr   (dump_done),
            .count (bin_cnt[g])
        );
    end

endmodule

// File: tb/tb_code_tally.sv
// Directed bench: two instances (CNT_W=8 and CNT_W=2) share all stimulus.
module tb_code_tally;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last;
    logic [2:0] a_out_bin;
    logic [7:0] a_out_count;
    logic       b_in_ready, b_out_valid, b_out_last;
    logic [2:0] b_out_bin;
    logic [1:0] b_out_count;

    int errors;
    int checks;
    int cyc;
    int exp_a [8];
    int exp_b [8];

    code_tally #(.CNT_W(8), .WIN(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_bin   (a_out_bin),
        .out_count (a_out_count),
        .out_last  (a_out_last)
    );

    code_tally #(.CNT_W(2), .WIN(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_bin   (b_out_bin),
        .out_count (b_out_count),
        .out_last  (b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected bin contents; dut_b saturates at 3
    task automatic set_exp(input int code, input int n, input bit all_bins);
        for (int b = 0; b < 8; b++) begin
            exp_a[b] = (all_bins || b == code) ? n : 0;
            exp_b[b] = (exp_a[b] > 3) ? 3 : exp_a[b];
        end
    endtask

    task automatic feed(input int n, input logic [2:0] code, input bit ramp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("collect_in_ready", 32'(a_in_ready), 32'd1);
            check("collect_out_valid", 32'(a_out_valid), 32'd0);
            in_valid = 1'b1;
            in_code  = ramp ? 3'(i % 8) : code;
        end
    endtask

    task automatic run_dump(input int stall_bin, input int stall_len,
                            input logic hold_v, input logic [2:0] hold_code);
        int t0;
        @(negedge clk);
        in_valid = hold_v;
        in_code  = hold_code;
        t0 = cyc;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) @(negedge clk);
            check("dump_valid_a", 32'(a_out_valid), 32'd1);
            check("dump_valid_b", 32'(b_out_valid), 32'd1);
            check("dump_in_ready", 32'(a_in_ready), 32'd0);
            check("dump_bin", 32'(a_out_bin), 32'(b));
            check("dump_bin_b", 32'(b_out_bin), 32'(b));
            check("dump_count_a", 32'(a_out_count), 32'(exp_a[b]));
            check("dump_count_b", 32'(b_out_count), 32'(exp_b[b]));
            check("dump_last", 32'(a_out_last), (b == 7) ? 32'd1 : 32'd0);
            if (b == stall_bin) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_valid", 32'(a_out_valid), 32'd1);
                    check("stall_bin", 32'(a_out_bin), 32'(b));
                    check("stall_count", 32'(a_out_count), 32'(exp_a[b]));
                    if (s == stall_len - 1) out_ready = 1'b1;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("post_dump_in_ready", 32'(a_in_ready), 32'd1);
        check("post_dump_in_ready_b", 32'(b_in_ready), 32'd1);
        check("post_dump_valid", 32'(a_out_valid), 32'd0);
        check("dump_cycles", 32'(cyc - t0), 32'(8 + ((stall_bin >= 0) ? stall_len : 0)));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("in_reset_valid", 32'(a_out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_count", 32'(a_out_count), 32'd0);
        check("rst_out_last", 32'(a_out_last), 32'd0);
        check("rst_out_bin", 32'(a_out_bin), 32'd0);

        // Codes 0..7 twice: every bin reads 2
        feed(16, 3'd0, 1'b1);
        set_exp(0, 2, 1'b1);
        run_dump(-1, 0, 1'b0, 3'd0);

        // All code 5: 16 in dut_a, saturated 3 in dut_b
        feed(16, 3'd5, 1'b0);
        set_exp(5, 16, 1'b0);
        run_dump(-1, 0, 1'b0, 3'd0);

        // Three-cycle stall on bin 2
        feed(16, 3'd0, 1'b1);
        set_exp(0, 2, 1'b1);
        run_dump(2, 3, 1'b0, 3'd0);

        // in_valid held with code 1 across the dump must not count
        feed(16, 3'd1, 1'b0);
        set_exp(1, 16, 1'b0);
        run_dump(-1, 0, 1'b1, 3'd1);
        feed(16, 3'd0, 1'b0);
        set_exp(0, 16, 1'b0);
        run_dump(-1, 0, 1'b0, 3'd0);

        // Gapped input, code 3 every other cycle
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            check("gap_no_dump", 32'(a_out_valid), 32'd0);
            in_valid = (i % 2 == 0);
            in_code  = 3'd3;
        end
        set_exp(3, 16, 1'b0);
        run_dump(-1, 0, 1'b0, 3'd0);

        // Reset after 10 accepts discards the partial window
        feed(10, 3'd2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_mid_valid", 32'(a_out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_mid_in_ready", 32'(a_in_ready), 32'd1);
        check("rel_mid_valid", 32'(a_out_valid), 32'd0);
        feed(15, 3'd4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("no_early_dump", 32'(a_out_valid), 32'd0);
        feed(1, 3'd4, 1'b0);
        set_exp(4, 16, 1'b0);
        run_dump(-1, 0, 1'b0, 3'd0);

        // Reset in the middle of a dump
        feed(16, 3'd6, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_dump_valid", 32'(a_out_valid), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("mid_dump_bin", 32'(a_out_bin), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_dump_valid", 32'(a_out_valid), 32'd0);
        check("rst_dump_bin", 32'(a_out_bin), 32'd0);
        check("rst_dump_count", 32'(a_out_count), 32'd0);
        check("rst_dump_in_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_dump_in_ready", 32'(a_in_ready), 32'd1);
        check("rel_dump_valid", 32'(a_out_valid), 32'd0);
        feed(16, 3'd7, 1'b0);
        set_exp(7, 16, 1'b0);
        run_dump(-1, 0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
